// File: rtl/vad_defs.sv
// Shared encodings for the classifier result and the smoother state.
// Also imported by the compare stage and by testbenches.
package vad_defs;

  localparam logic [1:0] RES_SPEECH = 2'b10;
  localparam logic [1:0] RES_NOISE  = 2'b01;

  typedef enum logic [1:0] {
    SILENCE = 2'b00,
    ONSET   = 2'b01,
    SPEECH  = 2'b10,
    HANG    = 2'b11
  } vad_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear and load-to-one; q_inc is the saturated q+1.
// Priority is clr, then load, then inc.
module sat_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         load,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic [W-1:0] q_inc
);

  localparam logic [W-1:0] MAX_VAL = '1;

  assign q_inc = (q == MAX_VAL) ? q : q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= W'(1);
    end else if (inc) begin
      q <= q_inc;
    end
  end

endmodule

// File: rtl/vad_hangover.sv
// Onset-confirm / hangover smoother over per-frame classifier decisions.
// Emits a registered speech flag, edge pulses and the length of each finished segment.
module vad_hangover
  import vad_defs::*;
#(
  parameter int ONSET_FRAMES = 3,
  parameter int HANG_FRAMES  = 8,
  parameter int CNT_W        = 4,
  parameter int LEN_W        = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             res_valid,
  input  logic [1:0]       res_in,
  output logic             vad_valid,
  output logic             vad_out,
  output logic             onset_pulse,
  output logic             offset_pulse,
  output logic [LEN_W-1:0] seg_len
);

  vad_state_t       state_reg, state_next;
  logic [CNT_W-1:0] ocnt_reg, ocnt_next;
  logic [CNT_W-1:0] hcnt_reg, hcnt_next;
  logic             onset_next, offset_next;
  logic             slen_inc, slen_load, slen_clr;
  logic [LEN_W-1:0] slen_q, slen_q_inc;
  logic             is_s, is_n;

  assign is_s = (res_in == RES_SPEECH);
  assign is_n = (res_in == RES_NOISE);

  sat_counter #(.W(LEN_W)) u_slen (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (slen_inc),
    .load  (slen_load),
    .clr   (slen_clr),
    .q     (slen_q),
    .q_inc (slen_q_inc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SILENCE;
      ocnt_reg  <= '0;
      hcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ocnt_reg  <= ocnt_next;
      hcnt_reg  <= hcnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ocnt_next   = ocnt_reg;
    hcnt_next   = hcnt_reg;
    onset_next  = 1'b0;
    offset_next = 1'b0;
    slen_inc    = 1'b0;
    slen_load   = 1'b0;
    slen_clr    = 1'b0;
    if (clear) begin
      state_next = SILENCE;
      ocnt_next  = '0;
      hcnt_next  = '0;
      slen_clr   = 1'b1;
    end else if (res_valid) begin
      // Ties fall through every branch below: only slen may advance.
      unique case (state_reg)
        SILENCE: begin
          if (is_s) begin
            if (ONSET_FRAMES == 1) begin
              state_next = SPEECH;
              onset_next = 1'b1;
              slen_load  = 1'b1;
            end else begin
              state_next = ONSET;
              ocnt_next  = CNT_W'(1);
            end
          end
        end
        ONSET: begin
          if (is_s) begin
            if ((ocnt_reg + 1'b1) == CNT_W'(ONSET_FRAMES)) begin
              state_next = SPEECH;
              ocnt_next  = '0;
              onset_next = 1'b1;
              slen_load  = 1'b1;
            end else begin
              ocnt_next = ocnt_reg + 1'b1;
            end
          end else if (is_n) begin
            state_next = SILENCE;
            ocnt_next  = '0;
          end
        end
        SPEECH: begin
          slen_inc = 1'b1;
          if (is_n) begin
            if (HANG_FRAMES == 0) begin
              state_next  = SILENCE;
              offset_next = 1'b1;
            end else begin
              state_next = HANG;
              hcnt_next  = CNT_W'(1);
            end
          end
        end
        HANG: begin
          slen_inc = 1'b1;
          if (is_s) begin
            state_next = SPEECH;
            hcnt_next  = '0;
          end else if (is_n) begin
            if (hcnt_reg == CNT_W'(HANG_FRAMES)) begin
              state_next  = SILENCE;
              hcnt_next   = '0;
              offset_next = 1'b1;
            end else begin
              hcnt_next = hcnt_reg + 1'b1;
            end
          end
        end
        default: state_next = SILENCE;
      endcase
      if (offset_next) slen_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vad_valid    <= 1'b0;
      vad_out      <= 1'b0;
      onset_pulse  <= 1'b0;
      offset_pulse <= 1'b0;
      seg_len      <= '0;
    end else if (clear) begin
      vad_valid    <= 1'b0;
      vad_out      <= 1'b0;
      onset_pulse  <= 1'b0;
      offset_pulse <= 1'b0;
      seg_len      <= '0;
    end else begin
      vad_valid    <= res_valid;
      vad_out      <= (state_next == SPEECH) || (state_next == HANG);
      onset_pulse  <= onset_next;
      offset_pulse <= offset_next;
      // The offset frame itself counts toward the reported length.
      if (offset_next) seg_len <= slen_q_inc;
    end
  end

endmodule

// File: tb/tb_vad_hangover.sv
// Bench for vad_hangover: fixed vectors, directed corner sequences, and random frames
// checked against a run-length model. A second instance uses LEN_W=4 for saturation.
module tb_vad_hangover;
  import vad_defs::*;

  localparam int ONSET = 3;
  localparam int HANG  = 8;
  localparam logic [1:0] S  = 2'b10;
  localparam logic [1:0] N  = 2'b01;
  localparam logic [1:0] T0 = 2'b00;
  localparam logic [1:0] T1 = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic res_valid = 1'b0;
  logic [1:0] res_in = 2'b00;
  logic [1:0] vv, vo, von, voff;
  logic [11:0] sl0;
  logic [3:0]  sl1;

  always #5 clk = ~clk;

  vad_hangover #(.ONSET_FRAMES(ONSET), .HANG_FRAMES(HANG), .CNT_W(4), .LEN_W(12)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .res_valid(res_valid), .res_in(res_in),
    .vad_valid(vv[0]), .vad_out(vo[0]), .onset_pulse(von[0]), .offset_pulse(voff[0]),
    .seg_len(sl0));

  vad_hangover #(.ONSET_FRAMES(ONSET), .HANG_FRAMES(HANG), .CNT_W(4), .LEN_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .res_valid(res_valid), .res_in(res_in),
    .vad_valid(vv[1]), .vad_out(vo[1]), .onset_pulse(von[1]), .offset_pulse(voff[1]),
    .seg_len(sl1));

  int total = 0;
  int bad = 0;
  int txn = 0;
  int n_on = 0;
  int n_off = 0;

  // Model: speaking flag, run lengths of S (outside speech) and N (inside speech).
  int m_spk[2], m_srun[2], m_nrun[2], m_len[2], m_seg[2];
  int e_valid[2], e_vad[2], e_on[2], e_off[2];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_spk[d] = 0; m_srun[d] = 0; m_nrun[d] = 0; m_len[d] = 0; m_seg[d] = 0;
      e_valid[d] = 0; e_vad[d] = 0; e_on[d] = 0; e_off[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input logic clr, input logic vld, input logic [1:0] res);
    int maxl;
    maxl = (d == 0) ? 4095 : 15;
    e_on[d] = 0;
    e_off[d] = 0;
    e_valid[d] = 0;
    if (clr) begin
      m_spk[d] = 0; m_srun[d] = 0; m_nrun[d] = 0; m_len[d] = 0; m_seg[d] = 0;
    end else if (vld) begin
      e_valid[d] = 1;
      if (m_spk[d] != 0) begin
        if (m_len[d] < maxl) m_len[d]++;
        if (res == S) m_nrun[d] = 0;
        else if (res == N) begin
          m_nrun[d]++;
          if (m_nrun[d] > HANG) begin
            m_spk[d] = 0; e_off[d] = 1; m_seg[d] = m_len[d]; m_len[d] = 0; m_nrun[d] = 0;
          end
        end
      end else begin
        if (res == S) begin
          m_srun[d]++;
          if (m_srun[d] >= ONSET) begin
            m_spk[d] = 1; e_on[d] = 1; m_len[d] = 1; m_srun[d] = 0;
          end
        end else if (res == N) m_srun[d] = 0;
      end
    end
    e_vad[d] = m_spk[d];
  endtask

  task automatic apply(input logic clr, input logic vld, input logic [1:0] res);
    @(negedge clk);
    clear = clr; res_valid = vld; res_in = res;
    @(posedge clk);
    #1;
    clear = 1'b0; res_valid = 1'b0;
    txn++;
    n_on += int'(von[0]);
    n_off += int'(voff[0]);
  endtask

  // One frame checked against the model on both instances.
  task automatic step(input logic clr, input logic vld, input logic [1:0] res);
    apply(clr, vld, res);
    for (int d = 0; d < 2; d++) model_step(d, clr, vld, res);
    chk("vad_valid0", int'(vv[0]), e_valid[0]);
    chk("vad_out0", int'(vo[0]), e_vad[0]);
    chk("onset0", int'(von[0]), e_on[0]);
    chk("offset0", int'(voff[0]), e_off[0]);
    chk("seg_len0", int'(sl0), m_seg[0]);
    chk("vad_out1", int'(vo[1]), e_vad[1]);
    chk("offset1", int'(voff[1]), e_off[1]);
    chk("seg_len1", int'(sl1), m_seg[1]);
    $display("txn %0d clr=%0b vld=%0b res=%b -> v=%0b vad=%0b on=%0b off=%0b seg=%0d/%0d",
             txn, clr, vld, res, vv[0], vo[0], von[0], voff[0], sl0, sl1);
  endtask

  typedef struct {
    logic clr; logic vld; logic [1:0] res;
    logic e_v; logic e_vad; logic e_on; logic e_off; int e_seg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic v, input logic [1:0] r,
                     input logic ev, input logic ed, input logic eon, input logic eoff, input int es);
    vec_t x;
    x.clr = c; x.vld = v; x.res = r; x.e_v = ev; x.e_vad = ed; x.e_on = eon; x.e_off = eoff; x.e_seg = es;
    vecs.push_back(x);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(vv[0]), 0);
    chk("rst_vad", int'(vo[0]), 0);
    chk("rst_on", int'(von[0]), 0);
    chk("rst_off", int'(voff[0]), 0);
    chk("rst_seg", int'(sl0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Onset, aborted onset, ties, then a hangover that tolerates ties.
    add(0,1,S, 1,0,0,0,0); add(0,1,S, 1,0,0,0,0); add(0,1,S, 1,1,1,0,0);
    add(1,0,S, 0,0,0,0,0);
    add(0,1,S, 1,0,0,0,0); add(0,1,S, 1,0,0,0,0); add(0,1,N, 1,0,0,0,0);
    add(0,1,S, 1,0,0,0,0); add(0,1,S, 1,0,0,0,0); add(0,1,S, 1,1,1,0,0);
    add(1,0,S, 0,0,0,0,0);
    add(0,1,S, 1,0,0,0,0); add(0,1,T0,1,0,0,0,0); add(0,1,S, 1,0,0,0,0);
    add(0,1,T1,1,0,0,0,0); add(0,1,S, 1,1,1,0,0);
    add(0,1,N, 1,1,0,0,0); add(0,1,T1,1,1,0,0,0); add(0,1,T0,1,1,0,0,0);
    for (int i = 0; i < 7; i++) add(0,1,N, 1,1,0,0,0);
    add(0,1,N, 1,0,0,1,12);
    add(0,0,N, 0,0,0,0,12);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].clr, vecs[i].vld, vecs[i].res);
      chk($sformatf("vec%0d_valid", i), int'(vv[0]), int'(vecs[i].e_v));
      chk($sformatf("vec%0d_vad", i), int'(vo[0]), int'(vecs[i].e_vad));
      chk($sformatf("vec%0d_on", i), int'(von[0]), int'(vecs[i].e_on));
      chk($sformatf("vec%0d_off", i), int'(voff[0]), int'(vecs[i].e_off));
      chk($sformatf("vec%0d_seg", i), int'(sl0), vecs[i].e_seg);
      $display("txn %0d vec %0d res=%b -> v=%0b vad=%0b on=%0b off=%0b seg=%0d",
               txn, i, vecs[i].res, vv[0], vo[0], von[0], voff[0], sl0);
    end

    // Hangover: 3 onset S + 2 S, then N x9 -> length 1+2+9.
    step(1, 0, N);
    repeat (5) step(0, 1, S);
    repeat (8) step(0, 1, N);
    chk("hang_held", int'(vo[0]), 1);
    step(0, 1, N);
    chk("hang_offset", int'(voff[0]), 1);
    chk("hang_seglen", int'(sl0), 12);

    // Hang rescue: exactly one onset and one offset.
    step(1, 0, N);
    n_on = 0; n_off = 0;
    repeat (4) step(0, 1, S);
    repeat (5) step(0, 1, N);
    step(0, 1, S);
    repeat (9) step(0, 1, N);
    chk("rescue_onsets", n_on, 1);
    chk("rescue_offsets", n_off, 1);

    // Saturation on LEN_W=4: 1 + 10 + 9 = 20 frames.
    step(1, 0, N);
    repeat (13) step(0, 1, S);
    repeat (9) step(0, 1, N);
    chk("sat_seg0", int'(sl0), 20);
    chk("sat_seg1", int'(sl1), 15);

    // clear together with a frame in SPEECH.
    repeat (4) step(0, 1, S);
    step(1, 1, N);
    chk("clr_valid", int'(vv[0]), 0);
    chk("clr_vad", int'(vo[0]), 0);
    chk("clr_off", int'(voff[0]), 0);

    // Asynchronous reset mid-segment, between clock edges.
    repeat (4) step(0, 1, S);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_vad", int'(vo[0]), 0);
    chk("arst_seg", int'(sl0), 0);
    chk("arst_off", int'(voff[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Random frames, occasional clear.
    for (int i = 0; i < 600; i++) begin
      logic c, v;
      logic [1:0] r;
      int k;
      c = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 99) < 75);
      k = $urandom_range(0, 9);
      r = (k < 5) ? S : (k < 9) ? N : ((k == 9) ? T0 : T1);
      if ($urandom_range(0, 20) == 0) r = T1;
      step(c, v, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
